// File: rtl/bp_update_sched.sv
// bp_update_sched: queues resolved-branch updates and drains them into the BHT
// write port when fetch is idle; also sequences a full-table invalidation walk.
`default_nettype none

module bp_update_sched #(
    parameter int PC_W    = 48,
    parameter int IDX_W   = 8,
    parameter int Q_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic                         ex_valid,
    input  logic [PC_W-1:0]              ex_pc,
    input  logic [PC_W-1:0]              ex_target,
    input  logic                         ex_taken,
    input  logic                         ex_mispred,
    output logic                         ex_ready,
    input  logic                         fetch_busy,
    output logic                         fetch_stall,
    input  logic                         inv_req,
    output logic                         inv_done,
    output logic                         bht_we,
    output logic [IDX_W-1:0]             bht_idx,
    output logic [PC_W-1:0]              bht_pc,
    output logic [PC_W-1:0]              bht_target,
    output logic                         bht_taken,
    output logic                         bht_mispred,
    output logic                         bht_inv,
    output logic [$clog2(Q_DEPTH):0]     q_count
);

    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] Q_FULL    = CNT_W'(Q_DEPTH);
    localparam logic [IDX_W:0]   WALK_LAST = {1'b0, {IDX_W{1'b1}}};

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PC_W-1:0]  pc_mem      [Q_DEPTH];
    logic [PC_W-1:0]  target_mem  [Q_DEPTH];
    logic             taken_mem   [Q_DEPTH];
    logic             mispred_mem [Q_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       wait_cnt;
    logic [IDX_W:0]   walk_idx;

    logic in_run, head_valid, forced, deq, enq, flush;

    assign in_run     = (state == RUN);
    assign head_valid = (count != '0);
    assign forced     = head_valid && (wait_cnt == 2'd3);
    assign deq        = in_run && head_valid && (!fetch_busy || forced);
    // Ready uses the pre-dequeue count, so a full queue never accepts while draining.
    assign ex_ready   = in_run && (count < Q_FULL) && n_reset;
    assign enq        = ex_valid && ex_ready;
    assign flush      = in_run && inv_req;
    assign q_count    = count;

    always_comb begin
        state_nxt   = state;
        bht_we      = 1'b0;
        bht_idx     = '0;
        bht_pc      = '0;
        bht_target  = '0;
        bht_taken   = 1'b0;
        bht_mispred = 1'b0;
        bht_inv     = 1'b0;
        fetch_stall = 1'b0;
        inv_done    = 1'b0;
        case (state)
            RUN: begin
                fetch_stall = forced;
                if (deq) begin
                    bht_we      = 1'b1;
                    bht_idx     = pc_mem[rd_ptr][IDX_W+1:2];
                    bht_pc      = pc_mem[rd_ptr];
                    bht_target  = target_mem[rd_ptr];
                    bht_taken   = taken_mem[rd_ptr];
                    bht_mispred = mispred_mem[rd_ptr];
                end
                if (inv_req) begin
                    state_nxt = WALK;
                end
            end
            WALK: begin
                bht_we      = 1'b1;
                bht_inv     = 1'b1;
                bht_idx     = walk_idx[IDX_W-1:0];
                fetch_stall = 1'b1;
                if (walk_idx == WALK_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                inv_done  = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= RUN;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
            walk_idx <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                wait_cnt <= '0;
                walk_idx <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (deq) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(enq) - CNT_W'(deq);
                if (deq || !head_valid) begin
                    wait_cnt <= '0;
                end else if (fetch_busy) begin
                    wait_cnt <= wait_cnt + 2'd1;
                end
                if (state == WALK) begin
                    walk_idx <= walk_idx + 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]      <= ex_pc;
            target_mem[wr_ptr]  <= ex_target;
            taken_mem[wr_ptr]   <= ex_taken;
            mispred_mem[wr_ptr] <= ex_mispred;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: directed vector table, hand sequences for invalidation and
// reset, and randomized traffic checked against a queue-based reference model.
`default_nettype none

module tb_bp_update_sched;

    localparam int PC_W = 48;
    localparam int IDX_W = 8;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic ex_valid = 1'b0, ex_taken = 1'b0, ex_mispred = 1'b0;
    logic [PC_W-1:0] ex_pc = '0, ex_target = '0;
    logic fetch_busy = 1'b0, inv_req = 1'b0;
    logic ex_ready, fetch_stall, inv_done, bht_we, bht_taken, bht_mispred, bht_inv;
    logic [IDX_W-1:0] bht_idx;
    logic [PC_W-1:0] bht_pc, bht_target;
    logic [2:0] q_count;

    bp_update_sched #(.PC_W(PC_W), .IDX_W(IDX_W), .Q_DEPTH(QD)) dut (
        .clk(clk), .n_reset(n_reset),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_taken(ex_taken), .ex_mispred(ex_mispred), .ex_ready(ex_ready),
        .fetch_busy(fetch_busy), .fetch_stall(fetch_stall),
        .inv_req(inv_req), .inv_done(inv_done),
        .bht_we(bht_we), .bht_idx(bht_idx), .bht_pc(bht_pc), .bht_target(bht_target),
        .bht_taken(bht_taken), .bht_mispred(bht_mispred), .bht_inv(bht_inv),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ready, stall, done, we, inv, taken, mispred;
        logic [IDX_W-1:0] idx;
        logic [PC_W-1:0]  pc, tgt;
        logic [2:0]       qc;
    } outs_t;

    typedef struct {
        logic [PC_W-1:0] pc, tgt;
        bit tk, mp;
    } ent_t;

    typedef struct {
        bit v; logic [PC_W-1:0] pc; bit fb;
        bit e_ready, e_we, e_stall; logic [7:0] e_idx; logic [PC_W-1:0] e_tgt; logic [2:0] e_qc;
    } vec_t;

    // Reference model: a plain queue, blocked-cycle count, and walk position.
    ent_t mq[$];
    int blocked, mode, walk;
    int vectors = 0, miscompares = 0;
    int inv_writes, dones;
    logic [PC_W-1:0] sent[$], got[$];
    outs_t last_act;

    function automatic outs_t actual();
        outs_t a;
        a = '{ready: ex_ready, stall: fetch_stall, done: inv_done, we: bht_we, inv: bht_inv,
              taken: bht_taken, mispred: bht_mispred, idx: bht_idx, pc: bht_pc,
              tgt: bht_target, qc: q_count};
        return a;
    endfunction

    task automatic model_reset();
        mq.delete(); blocked = 0; mode = 0; walk = 0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive, compare with model, clock, advance model.
    task automatic step(input bit v, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                        input bit tk, input bit mp, input bit fb, input bit inv);
        outs_t e, a;
        bit head, wr, acc;
        ex_valid = v; ex_pc = pc; ex_target = tgt; ex_taken = tk; ex_mispred = mp;
        fetch_busy = fb; inv_req = inv;
        #1;
        e = '0; head = 0; wr = 0;
        if (mode == 0) begin
            head = mq.size() > 0;
            e.ready = mq.size() < QD;
            e.qc = 3'(mq.size());
            e.stall = head && blocked >= 3;
            wr = head && (!fb || blocked >= 3);
            if (wr) begin
                e.we = 1; e.idx = mq[0].pc[IDX_W+1:2]; e.pc = mq[0].pc;
                e.tgt = mq[0].tgt; e.taken = mq[0].tk; e.mispred = mq[0].mp;
            end
        end else if (mode == 1) begin
            e.we = 1; e.inv = 1; e.stall = 1; e.idx = 8'(walk);
        end else begin
            e.done = 1;
        end
        a = actual();
        last_act = a;
        chk("model", 128'(a), 128'(e));
        if (a.we && a.inv) inv_writes++;
        if (a.done) dones++;
        if (a.we && !a.inv) got.push_back(a.pc);
        acc = v && a.ready;
        if (acc) sent.push_back(pc);
        @(posedge clk);
        if (mode == 0) begin
            if (wr) void'(mq.pop_front());
            if (v && e.ready) mq.push_back('{pc: pc, tgt: tgt, tk: tk, mp: mp});
            blocked = (wr || !head) ? 0 : blocked + 1;
            if (inv) begin
                mq.delete(); blocked = 0; mode = 1; walk = 0;
            end
        end else if (mode == 1) begin
            if (walk == (1 << IDX_W) - 1) mode = 2;
            else walk++;
        end else begin
            mode = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit fb);
        step(0, '0, '0, 0, 0, fb, 0);
    endtask

    function automatic vec_t mk(bit v, logic [PC_W-1:0] pc, bit fb, bit r, bit we, bit st,
                                logic [7:0] idx, logic [PC_W-1:0] tgt, logic [2:0] qc);
        vec_t t;
        t = '{v: v, pc: pc, fb: fb, e_ready: r, e_we: we, e_stall: st,
              e_idx: idx, e_tgt: tgt, e_qc: qc};
        return t;
    endfunction

    vec_t tbl[14];

    initial begin
        tbl[0]  = mk(1, 48'h1000, 0, 1, 0, 0, 8'h00, 48'h0,    3'd0);
        tbl[1]  = mk(0, 48'h0,    0, 1, 1, 0, 8'h00, 48'h2000, 3'd1);
        tbl[2]  = mk(0, 48'h0,    0, 1, 0, 0, 8'h00, 48'h0,    3'd0);
        tbl[3]  = mk(1, 48'h1004, 1, 1, 0, 0, 8'h00, 48'h0,    3'd0);
        tbl[4]  = mk(1, 48'h1008, 1, 1, 0, 0, 8'h00, 48'h0,    3'd1);
        tbl[5]  = mk(1, 48'h100C, 1, 1, 0, 0, 8'h00, 48'h0,    3'd2);
        tbl[6]  = mk(1, 48'h1010, 1, 1, 0, 0, 8'h00, 48'h0,    3'd3);
        tbl[7]  = mk(1, 48'h1014, 1, 0, 1, 1, 8'h01, 48'h2004, 3'd4);
        tbl[8]  = mk(0, 48'h0,    0, 1, 1, 0, 8'h02, 48'h2008, 3'd3);
        tbl[9]  = mk(1, 48'h1018, 0, 1, 1, 0, 8'h03, 48'h200C, 3'd2);
        tbl[10] = mk(1, 48'h101C, 0, 1, 1, 0, 8'h04, 48'h2010, 3'd2);
        tbl[11] = mk(0, 48'h0,    0, 1, 1, 0, 8'h06, 48'h2018, 3'd2);
        tbl[12] = mk(0, 48'h0,    0, 1, 1, 0, 8'h07, 48'h201C, 3'd1);
        tbl[13] = mk(0, 48'h0,    0, 1, 0, 0, 8'h00, 48'h0,    3'd0);

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_outputs", 128'(actual()), 128'(0));
        n_reset = 1'b1;

        // Directed table: single update, fill with forced write, enqueue+dequeue.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].pc, tbl[i].pc + 48'h1000, 1'b1, 1'b0, tbl[i].fb, 1'b0);
            chk($sformatf("table_row%0d", i),
                {last_act.ready, last_act.we, last_act.stall, last_act.idx, last_act.tgt, last_act.qc},
                {tbl[i].e_ready, tbl[i].e_we, tbl[i].e_stall, tbl[i].e_idx, tbl[i].e_tgt, tbl[i].e_qc});
        end

        // Invalidation with three queued entries.
        for (int i = 0; i < 3; i++)
            step(1, 48'h3000 + 48'(i * 4), 48'h4000, 0, 1, 1, 0);
        step(0, '0, '0, 0, 0, 0, 1);
        chk("inv_head_write", {last_act.we, last_act.inv, last_act.pc}, {1'b1, 1'b0, 48'h3000});
        inv_writes = 0; dones = 0;
        for (int i = 0; i < 257; i++) idle($urandom_range(0, 1));
        chk("inv_write_count", 128'(inv_writes), 128'(256));
        chk("inv_done_count", 128'(dones), 128'(1));
        idle(0);
        chk("post_inv_ready", {last_act.ready, last_act.qc}, {1'b1, 3'd0});

        // Asynchronous reset in the middle of a walk.
        step(0, '0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 100; i++) idle(0);
        fetch_busy = 1'b0; inv_req = 1'b0; ex_valid = 1'b0;
        #1;
        chk("walk_idx_100", {bht_we, bht_inv, bht_idx}, {1'b1, 1'b1, 8'd100});
        n_reset = 1'b0;
        #1;
        chk("mid_walk_reset_outputs", 128'(actual()), 128'(0));
        model_reset();
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 3; i++) idle(0);
        chk("no_done_after_reset", 128'(dones), 128'(0));
        chk("ready_after_reset", 128'(last_act.ready), 128'(1));

        // Ten updates trickled in with random fetch activity; all written once, in order.
        sent.delete(); got.delete();
        for (int i = 0; i < 10; i++) begin
            int tries;
            tries = 0;
            do begin
                step(1, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), 0);
                tries++;
            end while (sent.size() <= i && tries < 20);
            repeat ($urandom_range(0, 2)) idle($urandom_range(0, 1));
        end
        for (int i = 0; i < 20; i++) idle($urandom_range(0, 1));
        chk("trickle_sent", 128'(sent.size()), 128'(10));
        chk("trickle_written", 128'(got.size()), 128'(sent.size()));
        for (int i = 0; i < 10 && i < got.size() && i < sent.size(); i++)
            chk($sformatf("trickle_order%0d", i), 128'(got[i]), 128'(sent[i]));

        // Randomized traffic with occasional invalidations.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 1), {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 1), $urandom_range(0, 1), ($urandom % 4) != 0,
                 ($urandom % 400) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
